// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared constants for the common data bus arbiter
package cdb_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_TAG_W  = 3;
    localparam int DEF_DEPTH  = 2;

    localparam logic SRC_ADDSUB = 1'b0;
    localparam logic SRC_MULDIV = 1'b1;

    // FIFO entries are packed {tag, data}: tag occupies the MSBs.
    localparam int TAG_IN_MSBS = 1;

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - producer and broadcast signals of the CDB arbiter
interface cdb_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
);
    logic              as_valid;
    logic [TAG_W-1:0]  as_tag;
    logic [DATA_W-1:0] as_data;
    logic              as_ready;

    logic              md_valid;
    logic [TAG_W-1:0]  md_tag;
    logic [DATA_W-1:0] md_data;
    logic              md_ready;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              cdb_src;

    modport slave (
        input  as_valid, as_tag, as_data,
        input  md_valid, md_tag, md_data,
        output as_ready, md_ready,
        output cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport master (
        output as_valid, as_tag, as_data,
        output md_valid, md_tag, md_data,
        input  as_ready, md_ready,
        input  cdb_valid, cdb_tag, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_fifo.sv
// rtl/cdb_fifo.sv - small in-order result FIFO, one per functional unit
module cdb_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage needs no reset: the count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - buffers AddSub/MulDiv results and broadcasts one per cycle, round-robin
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);
    localparam int W = TAG_W + DATA_W;

    logic         as_push, md_push;
    logic         as_pop, md_pop;
    logic         as_full, md_full;
    logic         as_empty, md_empty;
    logic [W-1:0] as_dout, md_dout;

    logic         last_grant;
    logic         grant;
    logic         grant_src;
    logic [W-1:0] grant_entry;

    // Ready reflects only the registered count, so a full FIFO refuses even while being popped.
    assign bus.as_ready = !rst && !as_full;
    assign bus.md_ready = !rst && !md_full;

    assign as_push = bus.as_valid && bus.as_ready;
    assign md_push = bus.md_valid && bus.md_ready;

    cdb_fifo #(.W(W), .DEPTH(DEPTH)) u_as_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (as_push),
        .pop   (as_pop),
        .din   ({bus.as_tag, bus.as_data}),
        .dout  (as_dout),
        .full  (as_full),
        .empty (as_empty)
    );

    cdb_fifo #(.W(W), .DEPTH(DEPTH)) u_md_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (md_push),
        .pop   (md_pop),
        .din   ({bus.md_tag, bus.md_data}),
        .dout  (md_dout),
        .full  (md_full),
        .empty (md_empty)
    );

    always_comb begin
        grant     = 1'b0;
        grant_src = SRC_ADDSUB;
        if (!as_empty && !md_empty) begin
            grant     = 1'b1;
            grant_src = (last_grant == SRC_ADDSUB) ? SRC_MULDIV : SRC_ADDSUB;
        end else if (!as_empty) begin
            grant     = 1'b1;
            grant_src = SRC_ADDSUB;
        end else if (!md_empty) begin
            grant     = 1'b1;
            grant_src = SRC_MULDIV;
        end
    end

    assign grant_entry = (grant_src == SRC_MULDIV) ? md_dout : as_dout;
    assign as_pop      = grant && (grant_src == SRC_ADDSUB);
    assign md_pop      = grant && (grant_src == SRC_MULDIV);

    // Reset favours MulDiv as the last winner so the first tie goes to AddSub.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant    <= SRC_MULDIV;
            bus.cdb_valid <= 1'b0;
            bus.cdb_tag   <= '0;
            bus.cdb_data  <= '0;
            bus.cdb_src   <= SRC_ADDSUB;
        end else begin
            bus.cdb_valid <= grant;
            if (grant) begin
                last_grant   <= grant_src;
                bus.cdb_tag  <= grant_entry[W-1 -: TAG_W];
                bus.cdb_data <= grant_entry[DATA_W-1:0];
                bus.cdb_src  <= grant_src;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - table-driven and scoreboard checks of cdb_arbiter
module tb_cdb_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.DATA_W(16), .TAG_W(3)) bus ();

    cdb_arbiter #(.DATA_W(16), .TAG_W(3), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [2:0]  at;
        logic [15:0] ad;
        logic        mv;
        logic [2:0]  mt;
        logic [15:0] md;
        logic        ear;
        logic        emr;
        logic        ev;
        logic [2:0]  et;
        logic [15:0] ed;
        logic        es;
    } vec_t;

    typedef struct {
        logic [2:0]  tag;
        logic [15:0] data;
    } ent_t;

    int   checks   = 0;
    int   failures = 0;
    ent_t q_as[$];
    ent_t q_md[$];
    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [2:0] at, input logic [15:0] ad,
                         input logic mv, input logic [2:0] mt, input logic [15:0] md);
        bus.as_valid = av;
        bus.as_tag   = at;
        bus.as_data  = ad;
        bus.md_valid = mv;
        bus.md_tag   = mt;
        bus.md_data  = md;
    endtask

    // Scoreboard: record accepted results in producer order.
    always @(posedge clk) begin
        if (rst) begin
            q_as.delete();
            q_md.delete();
        end else begin
            if (bus.as_valid && bus.as_ready) q_as.push_back('{bus.as_tag, bus.as_data});
            if (bus.md_valid && bus.md_ready) q_md.push_back('{bus.md_tag, bus.md_data});
        end
    end

    // Every broadcast must match the oldest outstanding result of its source.
    always @(negedge clk) begin
        if (!rst && bus.cdb_valid) begin
            ent_t e;
            if (bus.cdb_src == 1'b0) begin
                if (q_as.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_as_unexpected tag=%0d data=%h", bus.cdb_tag, bus.cdb_data);
                end else begin
                    e = q_as.pop_front();
                    check("sb_as_entry", {13'd0, bus.cdb_tag, bus.cdb_data}, {13'd0, e.tag, e.data});
                end
            end else begin
                if (q_md.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_md_unexpected tag=%0d data=%h", bus.cdb_tag, bus.cdb_data);
                end else begin
                    e = q_md.pop_front();
                    check("sb_md_entry", {13'd0, bus.cdb_tag, bus.cdb_data}, {13'd0, e.tag, e.data});
                end
            end
        end
    end

    initial begin
        //          rst  av  at    ad         mv  mt    md        ear  emr  ev   et    ed        es
        vecs[0]  = '{1, 1, 3'd7, 16'h00ff, 0, 3'd0, 16'h0000, 0, 0, 0, 3'd0, 16'h0000, 0};
        vecs[1]  = '{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd0, 16'h0000, 0};
        vecs[2]  = '{0, 1, 3'd3, 16'h0005, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd0, 16'h0000, 0};
        vecs[3]  = '{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 1, 3'd3, 16'h0005, 0};
        vecs[4]  = '{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd3, 16'h0005, 0};
        vecs[5]  = '{1, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0, 3'd0, 16'h0000, 0};
        vecs[6]  = '{0, 1, 3'd1, 16'h000a, 1, 3'd4, 16'h0014, 1, 1, 0, 3'd0, 16'h0000, 0};
        vecs[7]  = '{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 1, 3'd1, 16'h000a, 0};
        vecs[8]  = '{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 1, 3'd4, 16'h0014, 1};
        vecs[9]  = '{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd4, 16'h0014, 1};
        vecs[10] = '{0, 1, 3'd0, 16'h0100, 1, 3'd4, 16'h0200, 1, 1, 0, 3'd4, 16'h0014, 1};
        vecs[11] = '{0, 1, 3'd1, 16'h0101, 1, 3'd5, 16'h0201, 1, 1, 1, 3'd0, 16'h0100, 0};
        vecs[12] = '{0, 1, 3'd2, 16'h0102, 1, 3'd6, 16'h0202, 1, 0, 1, 3'd4, 16'h0200, 1};
        vecs[13] = '{0, 1, 3'd3, 16'h0103, 1, 3'd6, 16'h0202, 0, 1, 1, 3'd1, 16'h0101, 0};
        vecs[14] = '{0, 1, 3'd3, 16'h0103, 1, 3'd7, 16'h0203, 1, 0, 1, 3'd5, 16'h0201, 1};
        vecs[15] = '{0, 1, 3'd4, 16'h0104, 1, 3'd7, 16'h0203, 0, 1, 1, 3'd2, 16'h0102, 0};
        vecs[16] = '{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 1, 3'd6, 16'h0202, 1};
        vecs[17] = '{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 1, 3'd3, 16'h0103, 0};
        vecs[18] = '{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 1, 3'd7, 16'h0203, 1};
        vecs[19] = '{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd7, 16'h0203, 1};

        rst = 1'b1;
        drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            drive(vecs[i].av, vecs[i].at, vecs[i].ad, vecs[i].mv, vecs[i].mt, vecs[i].md);
            #1;
            check($sformatf("row%0d_as_ready", i), {31'd0, bus.as_ready}, {31'd0, vecs[i].ear});
            check($sformatf("row%0d_md_ready", i), {31'd0, bus.md_ready}, {31'd0, vecs[i].emr});
            @(posedge clk);
            #1;
            check($sformatf("row%0d_cdb_valid", i), {31'd0, bus.cdb_valid}, {31'd0, vecs[i].ev});
            check($sformatf("row%0d_cdb_tag", i), {29'd0, bus.cdb_tag}, {29'd0, vecs[i].et});
            check($sformatf("row%0d_cdb_data", i), {16'd0, bus.cdb_data}, {16'd0, vecs[i].ed});
            check($sformatf("row%0d_cdb_src", i), {31'd0, bus.cdb_src}, {31'd0, vecs[i].es});
        end

        // Reset in the middle of traffic: output drops at once, stale entries vanish.
        @(negedge clk);
        drive(1, 3'd1, 16'h0301, 1, 3'd5, 16'h0401);
        @(negedge clk);
        drive(1, 3'd2, 16'h0302, 1, 3'd6, 16'h0402);
        @(posedge clk);
        #2;
        check("mid_pre_valid", {31'd0, bus.cdb_valid}, 32'd1);
        check("mid_pre_tag", {29'd0, bus.cdb_tag}, 32'd1);
        rst = 1'b1;
        drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        #1;
        check("mid_rst_valid", {31'd0, bus.cdb_valid}, 32'd0);
        check("mid_rst_as_ready", {31'd0, bus.as_ready}, 32'd0);
        check("mid_rst_md_ready", {31'd0, bus.md_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst_idle%0d", i), {31'd0, bus.cdb_valid}, 32'd0);
        end

        @(negedge clk);
        drive(1, 3'd2, 16'h0500, 1, 3'd3, 16'h0600);
        @(negedge clk);
        drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        @(posedge clk);
        #1;
        check("post_rst_tie1_valid", {31'd0, bus.cdb_valid}, 32'd1);
        check("post_rst_tie1_src", {31'd0, bus.cdb_src}, 32'd0);
        check("post_rst_tie1_tag", {29'd0, bus.cdb_tag}, 32'd2);
        @(posedge clk);
        #1;
        check("post_rst_tie2_valid", {31'd0, bus.cdb_valid}, 32'd1);
        check("post_rst_tie2_src", {31'd0, bus.cdb_src}, 32'd1);
        check("post_rst_tie2_tag", {29'd0, bus.cdb_tag}, 32'd3);
        repeat (3) @(posedge clk);
        #1;

        check("sb_as_drained", q_as.size(), 32'd0);
        check("sb_md_drained", q_md.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
